// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//
// Multi-channel push-button / switch debouncer with edge and long-press
// detection. Every channel is independent and owns:
//   - a 2-FF synchroniser (operating on the post-polarity value),
//   - a stability counter that qualifies a level change after WIN_CYC
//     consecutive disagreeing samples,
//   - a hold counter that flags a long press HOLD_CYC edges after the
//     debounced level went active.
//
// Parameters
//   CHANNELS     number of independent channels (>=1)
//   CLK_HZ       clock frequency in Hz
//   DEBOUNCE_MS  stability window, WIN_CYC  = (CLK_HZ/1000)*DEBOUNCE_MS (>=1)
//   HOLD_MS      long-press time,  HOLD_CYC = (CLK_HZ/1000)*HOLD_MS     (>=1)
//   ACTIVE_LOW   1: raw input is inverted before synchronising
//
// Ports
//   Clock      in   1         system clock, rising edge
//   Reset      in   1         synchronous, active-high reset
//   In         in   CHANNELS  raw asynchronous inputs
//   Out        out  CHANNELS  debounced level, 1 = active
//   Rise       out  CHANNELS  one-cycle strobe when Out goes 0->1
//   Fall       out  CHANNELS  one-cycle strobe when Out goes 1->0
//   Held       out  CHANNELS  1 while Out has been 1 for >= HOLD_CYC cycles
//   HeldPulse  out  CHANNELS  one-cycle strobe when Held goes 0->1
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 30,
  parameter int HOLD_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] In,
  output logic [CHANNELS-1:0] Out,
  output logic [CHANNELS-1:0] Rise,
  output logic [CHANNELS-1:0] Fall,
  output logic [CHANNELS-1:0] Held,
  output logic [CHANNELS-1:0] HeldPulse
);

  localparam int WIN_CYC  = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int HOLD_CYC = (CLK_HZ / 1000) * HOLD_MS;
  localparam int CW       = (WIN_CYC  > 1) ? $clog2(WIN_CYC + 1)  : 1;
  localparam int HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  // Terminal counts: reaching these on the current edge completes the window.
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  // Polarity is applied before synchronising so that reset (all zeros in the
  // synchroniser) always means "inactive", whatever the board wiring.
  logic [CHANNELS-1:0] in_pol;
  assign in_pol = In ^ {CHANNELS{ACTIVE_LOW}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          out_q,   out_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic [HW-1:0] hcnt_q,  hcnt_d;
    logic          held_q,  held_d;
    logic          hpulse_q, hpulse_d;
    logic          fall_commit;

    // Next-state logic: synchroniser, stability qualification, hold tracking.
    always_comb begin
      sync1_d     = in_pol[i];
      sync2_d     = sync1_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      hcnt_d      = hcnt_q;
      held_d      = held_q;
      hpulse_d    = 1'b0;
      fall_commit = 1'b0;

      // Any sample agreeing with the current level restarts the window, so
      // a bounce shorter than WIN_CYC never gets through.
      if (sync2_q == out_q) begin
        cnt_d = {CW{1'b0}};
      end else if (cnt_q == WIN_LAST) begin
        out_d       = sync2_q;
        cnt_d       = {CW{1'b0}};
        rise_d      = sync2_q;
        fall_d      = ~sync2_q;
        fall_commit = ~sync2_q;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end

      // The release takes priority: Held drops on the same edge as Out.
      // Once Held is set the counter stops, so HeldPulse fires once per press.
      if (fall_commit) begin
        held_d = 1'b0;
        hcnt_d = {HW{1'b0}};
      end else if (out_q && !held_q) begin
        if (hcnt_q == HOLD_LAST) begin
          held_d   = 1'b1;
          hpulse_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + {{(HW-1){1'b0}}, 1'b1};
        end
      end else begin
        hcnt_d = hcnt_q;
      end
    end

    // Channel state registers with synchronous reset; reset clears without strobes.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        cnt_q    <= {CW{1'b0}};
        out_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        hcnt_q   <= {HW{1'b0}};
        held_q   <= 1'b0;
        hpulse_q <= 1'b0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        hcnt_q   <= hcnt_d;
        held_q   <= held_d;
        hpulse_q <= hpulse_d;
      end
    end

    assign Out[i]       = out_q;
    assign Rise[i]      = rise_q;
    assign Fall[i]      = fall_q;
    assign Held[i]      = held_q;
    assign HeldPulse[i] = hpulse_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//
// Two instances with WIN_CYC=30 and HOLD_CYC=100: one active-high, one
// active-low fed with the inverted stimulus. Both must give the same outputs.
// Each table record drives Reset/In for n edges. Then it checks the final
// Out/Held, and the OR of Rise/Fall/HeldPulse seen over those n edges.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic [3:0] in_r;
  logic [3:0] in_n;

  logic [3:0] out0, rise0, fall0, held0, hp0;
  logic [3:0] out1, rise1, fall1, held1, hp1;

  logic [3:0] sr0, sf0, sh0, sr1, sf1, sh1;

  int vectors;
  int miscompares;

  assign in_n = ~in_r;

  debounce_bank #(.CHANNELS(4), .CLK_HZ(10000), .DEBOUNCE_MS(3), .HOLD_MS(10),
                  .ACTIVE_LOW(1'b0)) dut0 (
    .Clock(clk), .Reset(rst), .In(in_r),
    .Out(out0), .Rise(rise0), .Fall(fall0), .Held(held0), .HeldPulse(hp0));

  debounce_bank #(.CHANNELS(4), .CLK_HZ(10000), .DEBOUNCE_MS(3), .HOLD_MS(10),
                  .ACTIVE_LOW(1'b1)) dut1 (
    .Clock(clk), .Reset(rst), .In(in_n),
    .Out(out1), .Rise(rise1), .Fall(fall1), .Held(held1), .HeldPulse(hp1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] in;
    int         n;
    logic [3:0] out;
    logic [3:0] held;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] i, input int n,
                     input logic [3:0] o, input logic [3:0] h,
                     input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] hpu);
    vec_t v;
    v.rst = r; v.in = i; v.n = n; v.out = o; v.held = h;
    v.rise = ri; v.fall = fa; v.hp = hpu;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sr0 = sr0 | rise0; sf0 = sf0 | fall0; sh0 = sh0 | hp0;
    sr1 = sr1 | rise1; sf1 = sf1 | fall1; sh1 = sh1 | hp1;
  endtask

  task automatic chk_vec(input int idx, input int d, input logic [3:0] o,
                         input logic [3:0] h, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] p, input vec_t v);
    vectors++;
    if (o !== v.out || h !== v.held || r !== v.rise || f !== v.fall || p !== v.hp) begin
      miscompares++;
      $display("FAIL vec%0d dut%0d: got out=%b held=%b rise=%b fall=%b hp=%b, want out=%b held=%b rise=%b fall=%b hp=%b",
               idx, d, o, h, r, f, p, v.out, v.held, v.rise, v.fall, v.hp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vq[idx];
    rst  = v.rst;
    in_r = v.in;
    sr0 = 4'b0; sf0 = 4'b0; sh0 = 4'b0;
    sr1 = 4'b0; sf1 = 4'b0; sh1 = 4'b0;
    for (int k = 0; k < v.n; k++) step();
    chk_vec(idx, 0, out0, held0, sr0, sf0, sh0, v);
    chk_vec(idx, 1, out1, held1, sr1, sf1, sh1, v);
  endtask

  int split;
  int rc0, fc0, re0, rc1, fc1, re1;
  logic b;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    in_r = 4'b0000;
    sr0 = 4'b0; sf0 = 4'b0; sh0 = 4'b0;
    sr1 = 4'b0; sf1 = 4'b0; sh1 = 4'b0;

    //   rst   in       n   out      held     rise     fall     hp
    // Reset and single-channel qualification (edge 32)
    add(1'b1, 4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001, 31, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Long press: Held 100 edges after Out rose (edge 132)
    add(1'b0, 4'b0001, 98, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(1'b0, 4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // Release: Fall and Held clear on the same edge
    add(1'b0, 4'b0000, 31, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Short press of 50 cycles: no HeldPulse
    add(1'b0, 4'b0001, 31, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(1'b0, 4'b0001, 18, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 31, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    // Glitch of 29 cycles rejected, 30 cycles accepted on edge 32
    add(1'b0, 4'b0010, 29, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 40, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0010, 30, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000,  2, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 29, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    split = vq.size();
    // Simultaneous rise on all channels, then channel 3 released alone
    add(1'b1, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 31, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(1'b0, 4'b0111, 31, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0111,  1, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    // Re-press channel 3, let channels 0-2 reach Held
    add(1'b0, 4'b1111, 31, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 35, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111,  1, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0111);
    add(1'b0, 4'b1111,  4, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    // Reset mid-hold: outputs clear, no Fall, then requalify from scratch
    add(1'b1, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 31, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < split; i++) run_vec(i);

    // Bounce on channel 2: toggle every 10 cycles for 100 cycles, then hold 1
    rc0 = 0; fc0 = 0; rc1 = 0; fc1 = 0;
    for (int k = 0; k < 100; k++) begin
      b = ((k / 10) % 2) == 0;
      in_r = {1'b0, b, 2'b00};
      step();
      if (rise0[2]) rc0++;
      if (fall0[2]) fc0++;
      if (rise1[2]) rc1++;
      if (fall1[2]) fc1++;
    end
    chk_int("bounce_toggle_rise dut0", rc0, 0);
    chk_int("bounce_toggle_fall dut0", fc0, 0);
    chk_int("bounce_toggle_rise dut1", rc1, 0);
    chk_int("bounce_toggle_fall dut1", fc1, 0);
    in_r = 4'b0100;
    rc0 = 0; fc0 = 0; re0 = -1; rc1 = 0; fc1 = 0; re1 = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rise0[2]) begin rc0++; if (re0 < 0) re0 = k; end
      if (rise1[2]) begin rc1++; if (re1 < 0) re1 = k; end
      if (fall0[2]) fc0++;
      if (fall1[2]) fc1++;
    end
    chk_int("bounce_rise_edge dut0", re0, 32);
    chk_int("bounce_rise_count dut0", rc0, 1);
    chk_int("bounce_fall_count dut0", fc0, 0);
    chk_int("bounce_out dut0", int'(out0), 4);
    chk_int("bounce_rise_edge dut1", re1, 32);
    chk_int("bounce_rise_count dut1", rc1, 1);
    chk_int("bounce_fall_count dut1", fc1, 0);
    chk_int("bounce_out dut1", int'(out1), 4);

    for (int i = split; i < vq.size(); i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
